// File: rtl/envelope_if.sv
// rtl/envelope_if.sv - note inputs and envelope outputs shared by sequencer and envelope_gen
interface envelope_if #(
  parameter int AMP_W  = 3,
  parameter int TIME_W = 6
);
  logic              new_note;
  logic              beat;
  logic [AMP_W-1:0]  amplitude_in;
  logic [AMP_W-1:0]  sustain_in;
  logic [TIME_W-1:0] duration;
  logic [TIME_W-1:0] attack;
  logic [TIME_W-1:0] decay;
  logic [TIME_W-1:0] release_time;
  logic [AMP_W-1:0]  amplitude_out;
  logic [2:0]        phase;
  logic              busy;
  logic              done;

  modport master (
    output new_note, beat, amplitude_in, sustain_in, duration, attack, decay, release_time,
    input  amplitude_out, phase, busy, done
  );

  modport slave (
    input  new_note, beat, amplitude_in, sustain_in, duration, attack, decay, release_time,
    output amplitude_out, phase, busy, done
  );
endinterface

// File: rtl/envelope_gen.sv
// rtl/envelope_gen.sv - ADSR envelope generator with per-note slope divider
// Optional feature macro RETRIGGER_EN: new_note while busy restarts the note from the current level.
module envelope_gen #(
  parameter int AMP_W  = 3,
  parameter int TIME_W = 6
) (
  input  logic      clk,
  input  logic      reset,
  envelope_if.slave env
);
  localparam int F  = TIME_W;
  localparam int LW = AMP_W + F;
  localparam int SW = TIME_W + 2;
  localparam int BW = $clog2(LW);
  localparam logic [BW-1:0] LAST = BW'(LW - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, ATTACK = 3'd2, DECAY = 3'd3, SUSTAIN = 3'd4, RELEASE = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [AMP_W-1:0]  peak_q, sus_q;
  logic [TIME_W-1:0] dur_q, att_q, dec_q, rel_q;
  logic [LW-1:0]     level, level_nxt;
  logic [TIME_W-1:0] count, count_nxt;
  logic              done_q, done_nxt;
  logic [LW-1:0]     att_step, dec_step, rel_step;

  logic [1:0]        div_sel;
  logic [BW-1:0]     bit_cnt;
  logic [TIME_W-1:0] rem, rem_in, rem_nxt;
  logic [LW-2:0]     quo;
  logic [LW-1:0]     quo_nxt, step_val, numer;
  logic [AMP_W-1:0]  lvl_int, att_diff, num_int;
  logic [TIME_W-1:0] divisor;
  logic [TIME_W:0]   rem_sh, rem_diff;
  logic              q_bit, div_end, load_end, accept;

`ifdef RETRIGGER_EN
  assign accept = env.new_note;
`else
  assign accept = env.new_note && (state == IDLE);
`endif

  // Restoring divider: one quotient bit per clk, three divides in sequence.
  assign lvl_int  = level[LW-1:F];
  assign att_diff = (peak_q > lvl_int) ? peak_q - lvl_int : '0;

  always_comb begin
    num_int = att_diff;
    divisor = att_q;
    case (div_sel)
      2'd1:    begin num_int = peak_q - sus_q; divisor = dec_q; end
      2'd2:    begin num_int = sus_q;          divisor = rel_q; end
      default: ;
    endcase
  end

  assign numer    = {num_int, {F{1'b0}}};
  assign rem_in   = (bit_cnt == '0) ? '0 : rem;
  assign rem_sh   = {rem_in, numer[LAST - bit_cnt]};
  assign q_bit    = (rem_sh >= {1'b0, divisor});
  assign rem_diff = rem_sh - {1'b0, divisor};
  assign rem_nxt  = q_bit ? rem_diff[TIME_W-1:0] : rem_sh[TIME_W-1:0];
  assign quo_nxt  = {quo, q_bit};
  assign step_val = (divisor == '0) ? '0 : quo_nxt;
  assign div_end  = (bit_cnt == LAST);
  assign load_end = div_end && (div_sel == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_sel  <= '0;
      bit_cnt  <= '0;
      rem      <= '0;
      quo      <= '0;
      att_step <= '0;
      dec_step <= '0;
      rel_step <= '0;
    end else if (accept || state != LOAD) begin
      div_sel <= '0;
      bit_cnt <= '0;
      rem     <= '0;
      quo     <= '0;
    end else begin
      rem <= rem_nxt;
      quo <= quo_nxt[LW-2:0];
      if (div_end) begin
        bit_cnt <= '0;
        div_sel <= div_sel + 2'd1;
        case (div_sel)
          2'd0:    att_step <= step_val;
          2'd1:    dec_step <= step_val;
          default: rel_step <= step_val;
        endcase
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  logic [LW-1:0]     peak_full, sus_full, sub_step, level_step, level_sub;
  logic [LW:0]       level_add;
  logic [TIME_W-1:0] count_inc;
  logic [SW-1:0]     rel_sum, ad_sum;

  assign peak_full = {peak_q, {F{1'b0}}};
  assign sus_full  = {sus_q, {F{1'b0}}};
  assign count_inc = count + 1'b1;
  assign rel_sum   = SW'(count_inc) + SW'(rel_q);
  assign ad_sum    = SW'(att_q) + SW'(dec_q);

  always_comb begin
    state_nxt  = state;
    level_nxt  = level;
    count_nxt  = count;
    done_nxt   = 1'b0;
    level_add  = {1'b0, level} + {1'b0, att_step};
    sub_step   = (state == DECAY) ? dec_step : rel_step;
    level_sub  = (level > sub_step) ? level - sub_step : '0;
    level_step = level;
    case (state)
      ATTACK:         level_step = (level_add >= {1'b0, peak_full}) ? peak_full : level_add[LW-1:0];
      DECAY, RELEASE: level_step = (level_sub > peak_full) ? peak_full : level_sub;
      default:        ;
    endcase

    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: if (load_end) begin
        count_nxt = '0;
        if (dur_q == '0) begin
          state_nxt = IDLE;
          level_nxt = '0;
          done_nxt  = 1'b1;
        end else if (att_q != '0) begin
          state_nxt = ATTACK;
        end else if (dec_q != '0) begin
          state_nxt = DECAY;
          level_nxt = peak_full;
        end else begin
          state_nxt = SUSTAIN;
          level_nxt = sus_full;
        end
      end
      ATTACK, DECAY, SUSTAIN, RELEASE: if (env.beat) begin
        count_nxt = count_inc;
        level_nxt = level_step;
        if (count_inc == dur_q) begin
          state_nxt = IDLE;
          level_nxt = '0;
          done_nxt  = 1'b1;
        end else if (rel_sum >= SW'(dur_q) && state != RELEASE) begin
          state_nxt = RELEASE;
        end else if (state == ATTACK && count_inc == att_q) begin
          state_nxt = (dec_q == '0) ? SUSTAIN : DECAY;
          level_nxt = (dec_q == '0) ? sus_full : peak_full;
        end else if (state == DECAY && SW'(count_inc) == ad_sum) begin
          state_nxt = SUSTAIN;
          level_nxt = sus_full;
        end
      end
      default: state_nxt = IDLE;
    endcase

`ifdef RETRIGGER_EN
    if (accept && state != IDLE) begin
      state_nxt = LOAD;
      level_nxt = level;
      count_nxt = count;
      done_nxt  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      level  <= '0;
      count  <= '0;
      done_q <= 1'b0;
      peak_q <= '0;
      sus_q  <= '0;
      dur_q  <= '0;
      att_q  <= '0;
      dec_q  <= '0;
      rel_q  <= '0;
    end else begin
      state  <= state_nxt;
      level  <= level_nxt;
      count  <= count_nxt;
      done_q <= done_nxt;
      if (accept) begin
        peak_q <= env.amplitude_in;
        sus_q  <= (env.sustain_in > env.amplitude_in) ? env.amplitude_in : env.sustain_in;
        dur_q  <= env.duration;
        att_q  <= env.attack;
        dec_q  <= env.decay;
        rel_q  <= env.release_time;
      end
    end
  end

  assign env.amplitude_out = level[LW-1:F];
  assign env.phase         = state;
  assign env.busy          = (state != IDLE);
  assign env.done          = done_q;
endmodule

// File: tb/tb_envelope_gen.sv
// tb/tb_envelope_gen.sv - scoreboard bench for envelope_gen
module tb_envelope_gen;
  localparam int AMP_W  = 3;
  localparam int TIME_W = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  envelope_if #(.AMP_W(AMP_W), .TIME_W(TIME_W)) env ();

  envelope_gen #(.AMP_W(AMP_W), .TIME_W(TIME_W)) dut (
    .clk   (clk),
    .reset (reset),
    .env   (env)
  );

  typedef struct {
    logic [2:0] out;
    logic [2:0] ph;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_pulse();
    repeat (28) tick();
    env.beat = 1'b1;
    tick();
    env.beat = 1'b0;
  endtask

  task automatic push(input int o, input int p, input int d);
    exp_t e;
    e.out = 3'(o);
    e.ph  = 3'(p);
    e.dn  = 1'(d);
    sb.push_back(e);
  endtask

  task automatic start_note(input int pk, input int sus, input int dur, input int a,
                            input int d, input int r, input bit inject, output int load_cycles);
    env.amplitude_in = AMP_W'(pk);
    env.sustain_in   = AMP_W'(sus);
    env.duration     = TIME_W'(dur);
    env.attack       = TIME_W'(a);
    env.decay        = TIME_W'(d);
    env.release_time = TIME_W'(r);
    env.new_note     = 1'b1;
    tick();
    env.new_note     = 1'b0;
    env.amplitude_in = '0;
    env.sustain_in   = '0;
    env.duration     = '0;
    load_cycles = 0;
    while (env.phase == 3'd1 && load_cycles < 100) begin
      load_cycles++;
      if (inject && (load_cycles == 5 || load_cycles == 12 || load_cycles == 20)) env.beat = 1'b1;
      tick();
      env.beat = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (env.amplitude_out !== 3'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", env.amplitude_out); end
    checks++; if (env.phase !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", env.phase); end
    checks++; if (env.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", env.busy); end
    checks++; if (env.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", env.done); end
  endtask

  task automatic test_full_adsr();
    int lc;
    exp_t e;
    int outs[20] = '{1,2,3,4,5,6,7,6,5,4,3,3,3,3,3,3,3,2,1,0};
    int phs[20]  = '{2,2,2,2,2,2,3,3,3,3,4,4,4,4,4,4,5,5,5,0};
    start_note(7, 3, 20, 7, 4, 3, 1'b0, lc);
    checks++; if (lc != 27) begin errors++; $display("FAIL adsr_load_len: got %0d expected 27", lc); end
    checks++; if (env.phase !== 3'd2) begin errors++; $display("FAIL adsr_enter_attack: got %0d expected 2", env.phase); end
    for (int i = 0; i < 20; i++) begin
      push(outs[i], phs[i], (i == 19) ? 1 : 0);
      beat_pulse();
      e = sb.pop_front();
      checks++; if (env.amplitude_out !== e.out) begin errors++; $display("FAIL adsr_out beat %0d: got %0d expected %0d", i + 1, env.amplitude_out, e.out); end
      checks++; if (env.phase !== e.ph) begin errors++; $display("FAIL adsr_phase beat %0d: got %0d expected %0d", i + 1, env.phase, e.ph); end
      checks++; if (env.done !== e.dn) begin errors++; $display("FAIL adsr_done beat %0d: got %0b expected %0b", i + 1, env.done, e.dn); end
    end
    checks++; if (env.busy !== 1'b0) begin errors++; $display("FAIL adsr_busy_end: got %0b expected 0", env.busy); end
    tick();
    checks++; if (env.done !== 1'b0) begin errors++; $display("FAIL adsr_done_width: got %0b expected 0", env.done); end
  endtask

  task automatic test_load_latency();
    int lc;
    exp_t e;
    start_note(7, 3, 20, 7, 4, 3, 1'b1, lc);
    checks++; if (lc != 27) begin errors++; $display("FAIL load_len_with_beats: got %0d expected 27", lc); end
    for (int i = 1; i <= 7; i++) begin
      push(i, (i == 7) ? 3 : 2, 0);
      beat_pulse();
      e = sb.pop_front();
      checks++; if (env.amplitude_out !== e.out) begin errors++; $display("FAIL load_count_out beat %0d: got %0d expected %0d", i, env.amplitude_out, e.out); end
      checks++; if (env.phase !== e.ph) begin errors++; $display("FAIL load_count_phase beat %0d: got %0d expected %0d", i, env.phase, e.ph); end
    end
    pulse_reset();
  endtask

  task automatic test_zero_attack_decay();
    int lc;
    exp_t e;
    start_note(5, 5, 4, 0, 0, 0, 1'b0, lc);
    checks++; if (env.amplitude_out !== 3'd5) begin errors++; $display("FAIL zad_load_out: got %0d expected 5", env.amplitude_out); end
    checks++; if (env.phase !== 3'd4) begin errors++; $display("FAIL zad_load_phase: got %0d expected 4", env.phase); end
    for (int i = 1; i <= 4; i++) begin
      push((i == 4) ? 0 : 5, (i == 4) ? 0 : 4, (i == 4) ? 1 : 0);
      beat_pulse();
      e = sb.pop_front();
      checks++; if (env.amplitude_out !== e.out) begin errors++; $display("FAIL zad_out beat %0d: got %0d expected %0d", i, env.amplitude_out, e.out); end
      checks++; if (env.phase !== e.ph) begin errors++; $display("FAIL zad_phase beat %0d: got %0d expected %0d", i, env.phase, e.ph); end
      checks++; if (env.done !== e.dn) begin errors++; $display("FAIL zad_done beat %0d: got %0b expected %0b", i, env.done, e.dn); end
    end
  endtask

  task automatic test_release_overlap();
    int lc;
    exp_t e;
    int outs[8] = '{1,2,1,0,0,0,0,0};
    int phs[8]  = '{2,5,5,5,5,5,5,0};
    start_note(7, 7, 8, 6, 0, 6, 1'b0, lc);
    for (int i = 0; i < 8; i++) begin
      push(outs[i], phs[i], (i == 7) ? 1 : 0);
      beat_pulse();
      e = sb.pop_front();
      checks++; if (env.amplitude_out !== e.out) begin errors++; $display("FAIL rel_out beat %0d: got %0d expected %0d", i + 1, env.amplitude_out, e.out); end
      checks++; if (env.phase !== e.ph) begin errors++; $display("FAIL rel_phase beat %0d: got %0d expected %0d", i + 1, env.phase, e.ph); end
      checks++; if (env.done !== e.dn) begin errors++; $display("FAIL rel_done beat %0d: got %0b expected %0b", i + 1, env.done, e.dn); end
    end
  endtask

  task automatic test_dur0_clamp();
    int lc;
    exp_t e;
    start_note(7, 3, 0, 2, 2, 2, 1'b0, lc);
    checks++; if (lc != 27) begin errors++; $display("FAIL dur0_load_len: got %0d expected 27", lc); end
    checks++; if (env.done !== 1'b1) begin errors++; $display("FAIL dur0_done: got %0b expected 1", env.done); end
    checks++; if (env.phase !== 3'd0) begin errors++; $display("FAIL dur0_phase: got %0d expected 0", env.phase); end
    checks++; if (env.amplitude_out !== 3'd0) begin errors++; $display("FAIL dur0_out: got %0d expected 0", env.amplitude_out); end
    tick();
    start_note(4, 6, 3, 0, 0, 0, 1'b0, lc);
    checks++; if (env.amplitude_out !== 3'd4) begin errors++; $display("FAIL clamp_load_out: got %0d expected 4", env.amplitude_out); end
    for (int i = 1; i <= 3; i++) begin
      push((i == 3) ? 0 : 4, (i == 3) ? 0 : 4, (i == 3) ? 1 : 0);
      beat_pulse();
      e = sb.pop_front();
      checks++; if (env.amplitude_out !== e.out) begin errors++; $display("FAIL clamp_out beat %0d: got %0d expected %0d", i, env.amplitude_out, e.out); end
      checks++; if (env.done !== e.dn) begin errors++; $display("FAIL clamp_done beat %0d: got %0b expected %0b", i, env.done, e.dn); end
    end
  endtask

  task automatic test_reset_mid_decay();
    int lc;
    exp_t e;
    int outs[9] = '{1,2,3,4,5,6,7,6,5};
    start_note(7, 3, 20, 7, 4, 3, 1'b0, lc);
    for (int i = 0; i < 9; i++) begin
      push(outs[i], (i < 6) ? 2 : 3, 0);
      beat_pulse();
      e = sb.pop_front();
      checks++; if (env.amplitude_out !== e.out) begin errors++; $display("FAIL rst_pre_out beat %0d: got %0d expected %0d", i + 1, env.amplitude_out, e.out); end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (env.amplitude_out !== 3'd0) begin errors++; $display("FAIL rst_mid_out: got %0d expected 0", env.amplitude_out); end
    checks++; if (env.phase !== 3'd0) begin errors++; $display("FAIL rst_mid_phase: got %0d expected 0", env.phase); end
    checks++; if (env.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %0b expected 0", env.busy); end
    checks++; if (env.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %0b expected 0", env.done); end
    tick();
    checks++; if (env.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done_late: got %0b expected 0", env.done); end
  endtask

`ifdef RETRIGGER_EN
  task automatic test_busy_note();
    int lc;
    exp_t e;
    start_note(7, 3, 20, 7, 4, 3, 1'b0, lc);
    for (int i = 1; i <= 4; i++) beat_pulse();
    checks++; if (env.amplitude_out !== 3'd4) begin errors++; $display("FAIL retrig_pre_out: got %0d expected 4", env.amplitude_out); end
    start_note(7, 7, 10, 3, 0, 0, 1'b0, lc);
    checks++; if (lc != 27) begin errors++; $display("FAIL retrig_load_len: got %0d expected 27", lc); end
    checks++; if (env.amplitude_out !== 3'd4) begin errors++; $display("FAIL retrig_keep_level: got %0d expected 4", env.amplitude_out); end
    for (int i = 1; i <= 3; i++) begin
      push(4 + i, (i == 3) ? 4 : 2, 0);
      beat_pulse();
      e = sb.pop_front();
      checks++; if (env.amplitude_out !== e.out) begin errors++; $display("FAIL retrig_out beat %0d: got %0d expected %0d", i, env.amplitude_out, e.out); end
      checks++; if (env.phase !== e.ph) begin errors++; $display("FAIL retrig_phase beat %0d: got %0d expected %0d", i, env.phase, e.ph); end
    end
    pulse_reset();
  endtask
`else
  task automatic test_busy_note();
    int lc;
    exp_t e;
    start_note(7, 3, 20, 7, 4, 3, 1'b0, lc);
    for (int i = 1; i <= 3; i++) beat_pulse();
    start_note(2, 1, 1, 0, 0, 0, 1'b0, lc);
    checks++; if (env.phase !== 3'd2) begin errors++; $display("FAIL busy_note_phase: got %0d expected 2", env.phase); end
    checks++; if (env.amplitude_out !== 3'd3) begin errors++; $display("FAIL busy_note_out: got %0d expected 3", env.amplitude_out); end
    push(4, 2, 0);
    beat_pulse();
    e = sb.pop_front();
    checks++; if (env.amplitude_out !== e.out) begin errors++; $display("FAIL busy_note_beat4: got %0d expected %0d", env.amplitude_out, e.out); end
    checks++; if (env.done !== e.dn) begin errors++; $display("FAIL busy_note_done: got %0b expected %0b", env.done, e.dn); end
    pulse_reset();
  endtask
`endif

  initial begin
    reset            = 1'b1;
    env.new_note     = 1'b0;
    env.beat         = 1'b0;
    env.amplitude_in = '0;
    env.sustain_in   = '0;
    env.duration     = '0;
    env.attack       = '0;
    env.decay        = '0;
    env.release_time = '0;
    repeat (3) tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_full_adsr();
    test_load_latency();
    test_zero_attack_decay();
    test_release_overlap();
    test_dur0_clamp();
    test_reset_mid_decay();
    test_busy_note();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/envelope_gen.md
Name: envelope_gen

Overview:
Parametrised ADSR amplitude envelope generator for one voice. It is the next generation of the note-dynamics stage and sits between the note sequencer and the tone mixer. On each note it ramps linearly through attack to the peak, decays to a programmable sustain level, holds, then releases to zero by the end of the note duration. Ramps use fixed-point slopes computed once per note by an internal sequential divider.

Parameters:
AMP_W, 3, amplitude width in bits.
TIME_W, 6, width of duration/attack/decay/release in beats. The fractional bits of the level accumulator F = TIME_W.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
new_note  in  1  single-cycle pulse that latches all note inputs
beat  in  1  single-cycle timing tick (1/48 s)
amplitude_in  in  AMP_W  peak amplitude
sustain_in  in  AMP_W  sustain level; values above peak are clamped to peak at latch
duration  in  TIME_W  note length in beats
attack  in  TIME_W  attack length in beats
decay  in  TIME_W  decay length in beats
release  in  TIME_W  release length in beats
amplitude_out  out  AMP_W  integer part of the level register
phase  out  3  0=IDLE, 1=LOAD, 2=ATTACK, 3=DECAY, 4=SUSTAIN, 5=RELEASE
busy  out  1  high whenever phase is not IDLE
done  out  1  one-clk pulse when a note returns to IDLE

Behaviour:
- Reset: phase IDLE, level 0, count 0, amplitude_out 0, busy 0, done 0. Reset takes effect mid-note and mid-divide, and no done pulse is produced.
- IDLE: on new_note, latch all inputs and go to LOAD. The note uses only the latched values, so inputs may change afterwards.
- LOAD: a restoring divider produces one quotient bit per clk. It runs three divides back-to-back, each AMP_W+TIME_W clks, giving 27 clks total at the defaults.
  - attack_step = ((peak - level_int) << F) / attack
  - decay_step = ((peak - sus) << F) / decay
  - release_step = (sus << F) / release
  - A divisor of 0 gives step 0. A negative numerator saturates to 0.
  - Beats during LOAD are ignored.
  - At LOAD end, count = 0. If duration == 0, go to IDLE with level 0 and pulse done. Otherwise enter ATTACK, or DECAY if attack == 0 (level := peak), or SUSTAIN if decay == 0 too (level := sus).
- Active phases, per beat:
  - count := count+1.
  - Update the level with the current phase's step: add in ATTACK, subtract in DECAY and RELEASE, saturating within 0..peak.
  - Evaluate transitions on the new count, in priority order:
    1. new count == duration: level := 0, go to IDLE, done pulse.
    2. new count + release >= duration and phase != RELEASE: go to RELEASE. The level is not snapped.
    3. ATTACK and new count == attack: level := peak, go to DECAY (or SUSTAIN if decay == 0, with level := sus).
    4. DECAY and new count == attack+decay: level := sus, go to SUSTAIN.
- Width rules:
  - Compare sums at TIME_W+2 bits so they never wrap.
  - The level register is AMP_W+F bits.
  - amplitude_out = level[AMP_W+F-1:F].
- new_note while busy is ignored unless the optional feature is compiled in.
- Timing constraint: beats are at least 3*(AMP_W+TIME_W)+1 clks apart.

Optional Feature:
RETRIGGER_EN.
- Defined: new_note while busy re-latches the inputs and re-enters LOAD, keeping the current level. Attack then ramps from that level (see attack_step). A retrigger in the same clk as a terminal beat wins, and no done pulse is produced.
- Undefined: new_note while busy has no effect.

Test Plan:
- Full ADSR: peak=7, sus=3, A=7, D=4, R=3, dur=20.
  - beats 1-7 give out 1..7; beats 8-11 give 6,5,4,3.
  - beats 12-17 give 3; beats 18-20 give 2,1,0.
  - done pulses after beat 20 and busy falls.
- LOAD latency: new_note -> phase=LOAD for exactly 27 clks, and 3 beats injected during LOAD leave count 0.
- Zero attack/decay: peak=5, sus=5, A=0, D=0, R=0, dur=4 -> out=5 at LOAD end, 5 for beats 1-3, 0 on beat 4 with done.
- Release overlap: peak=7, sus=7, A=6, D=0, R=6, dur=8 -> RELEASE entered at beat 2 with out=2, level falls by 7/6 per beat, and out=0 at beat 8.
- Duration 0 and sustain clamp: dur=0 -> done at LOAD end with out 0; sus=6, peak=4 -> sustain output 4.
- Reset mid-DECAY -> next clk out=0, phase=0, busy=0, no done. Under RETRIGGER_EN: new_note at out=4 with peak=7, A=3 -> out 5,6,7 on beats 1-3.
